// File: rtl/accelerator_standard_fnn_sequencer_pkg.sv
// rtl/accelerator_standard_fnn_sequencer_pkg.sv - states, phases and phase-to-dimension mapping
package accelerator_standard_fnn_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD_W  = 4'd1,
      S_LOAD_K  = 4'd2,
      S_LOAD_U  = 4'd3,
      S_LOAD_B  = 4'd4,
      S_LOAD_X  = 4'd5,
      S_LOAD_R  = 4'd6,
      S_LOAD_H  = 4'd7,
      S_RUN     = 4'd8,
      S_COLLECT = 4'd9,
      S_DONE    = 4'd10
   } state_t;

   typedef enum logic [2:0] {PH_W, PH_K, PH_U, PH_B, PH_X, PH_R, PH_H} phase_t;

   localparam int NUM_PHASES = 7;

   typedef enum logic [2:0] {DIM_ONE, DIM_X, DIM_W, DIM_L, DIM_R} dim_t;

   typedef struct packed {
      dim_t outer;
      dim_t mid;
      dim_t inner;
   } phase_dims_t;

   typedef struct packed {
      logic w_l, w_x, k_i, k_l, k_k, u_l, u_p, b, x, r_i, r_k, h;
   } fnn_en_t;

   // Unused outer levels are size one so every phase runs on the same 3-level counter
   function automatic phase_dims_t phase_dims(input phase_t p);
      case (p)
         PH_W:    return '{DIM_ONE, DIM_L, DIM_X};
         PH_K:    return '{DIM_R, DIM_L, DIM_W};
         PH_U:    return '{DIM_ONE, DIM_L, DIM_L};
         PH_B:    return '{DIM_ONE, DIM_ONE, DIM_L};
         PH_X:    return '{DIM_ONE, DIM_ONE, DIM_X};
         PH_R:    return '{DIM_ONE, DIM_R, DIM_W};
         default: return '{DIM_ONE, DIM_ONE, DIM_L};
      endcase
   endfunction

endpackage

// File: rtl/accelerator_standard_fnn_sequencer_if.sv
// rtl/accelerator_standard_fnn_sequencer_if.sv - control, operand stream, accelerator and result signals
interface accelerator_standard_fnn_sequencer_if #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
);
   logic                    CTRL_START;
   logic                    CTRL_BUSY;
   logic                    CTRL_DONE;
   logic [CONTROL_SIZE-1:0] SIZE_X_IN;
   logic [CONTROL_SIZE-1:0] SIZE_W_IN;
   logic [CONTROL_SIZE-1:0] SIZE_L_IN;
   logic [CONTROL_SIZE-1:0] SIZE_R_IN;
   logic                    SRC_VALID;
   logic                    SRC_READY;
   logic [DATA_SIZE-1:0]    SRC_DATA;
   logic                    FNN_START;
   logic                    FNN_READY;
   logic                    FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE;
   logic                    FNN_K_IN_I_ENABLE, FNN_K_IN_L_ENABLE, FNN_K_IN_K_ENABLE;
   logic                    FNN_U_IN_L_ENABLE, FNN_U_IN_P_ENABLE;
   logic                    FNN_B_IN_ENABLE, FNN_X_IN_ENABLE, FNN_H_IN_ENABLE;
   logic                    FNN_R_IN_I_ENABLE, FNN_R_IN_K_ENABLE;
   logic [DATA_SIZE-1:0]    FNN_W_IN, FNN_K_IN, FNN_U_IN, FNN_B_IN, FNN_X_IN, FNN_R_IN, FNN_H_IN;
   logic                    FNN_H_OUT_ENABLE;
   logic [DATA_SIZE-1:0]    FNN_H_OUT;
   logic                    DST_VALID;
   logic [DATA_SIZE-1:0]    DST_DATA;

   modport master (
      input  CTRL_START, SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN,
      input  SRC_VALID, SRC_DATA, FNN_READY, FNN_H_OUT_ENABLE, FNN_H_OUT,
      output CTRL_BUSY, CTRL_DONE, SRC_READY, FNN_START,
      output FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE,
      output FNN_K_IN_I_ENABLE, FNN_K_IN_L_ENABLE, FNN_K_IN_K_ENABLE,
      output FNN_U_IN_L_ENABLE, FNN_U_IN_P_ENABLE,
      output FNN_B_IN_ENABLE, FNN_X_IN_ENABLE, FNN_H_IN_ENABLE,
      output FNN_R_IN_I_ENABLE, FNN_R_IN_K_ENABLE,
      output FNN_W_IN, FNN_K_IN, FNN_U_IN, FNN_B_IN, FNN_X_IN, FNN_R_IN, FNN_H_IN,
      output DST_VALID, DST_DATA
   );

   modport slave (
      output CTRL_START, SIZE_X_IN, SIZE_W_IN, SIZE_L_IN, SIZE_R_IN,
      output SRC_VALID, SRC_DATA, FNN_READY, FNN_H_OUT_ENABLE, FNN_H_OUT,
      input  CTRL_BUSY, CTRL_DONE, SRC_READY, FNN_START,
      input  FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE,
      input  FNN_K_IN_I_ENABLE, FNN_K_IN_L_ENABLE, FNN_K_IN_K_ENABLE,
      input  FNN_U_IN_L_ENABLE, FNN_U_IN_P_ENABLE,
      input  FNN_B_IN_ENABLE, FNN_X_IN_ENABLE, FNN_H_IN_ENABLE,
      input  FNN_R_IN_I_ENABLE, FNN_R_IN_K_ENABLE,
      input  FNN_W_IN, FNN_K_IN, FNN_U_IN, FNN_B_IN, FNN_X_IN, FNN_R_IN, FNN_H_IN,
      input  DST_VALID, DST_DATA
   );
endinterface

// File: rtl/accelerator_standard_fnn_index_counter.sv
// rtl/accelerator_standard_fnn_index_counter.sv - 3-level wrapping index counter, innermost level fastest
module accelerator_standard_fnn_index_counter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] size_outer,
   input  logic [WIDTH-1:0] size_mid,
   input  logic [WIDTH-1:0] size_inner,
   output logic             zero_inner,
   output logic             zero_mid,
   output logic             last
);
   logic [WIDTH-1:0] idx_outer, idx_mid, idx_inner;
   logic             at_outer, at_mid, at_inner;

   assign at_inner   = (idx_inner == size_inner - WIDTH'(1));
   assign at_mid     = (idx_mid   == size_mid   - WIDTH'(1));
   assign at_outer   = (idx_outer == size_outer - WIDTH'(1));
   assign zero_inner = (idx_inner == '0);
   assign zero_mid   = (idx_mid   == '0);
   assign last       = at_outer && at_mid && at_inner;

   // The last element wraps every level, so indices are already zero for the next phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_outer <= '0;
         idx_mid   <= '0;
         idx_inner <= '0;
      end else if (clear) begin
         idx_outer <= '0;
         idx_mid   <= '0;
         idx_inner <= '0;
      end else if (inc) begin
         if (at_inner) begin
            idx_inner <= '0;
            if (at_mid) begin
               idx_mid <= '0;
               idx_outer <= at_outer ? '0 : idx_outer + WIDTH'(1);
            end else begin
               idx_mid <= idx_mid + WIDTH'(1);
            end
         end else begin
            idx_inner <= idx_inner + WIDTH'(1);
         end
      end
   end
endmodule

// File: rtl/accelerator_standard_fnn_sequencer.sv
// rtl/accelerator_standard_fnn_sequencer.sv - splits the operand stream into FNN tensors, starts the core, collects H_OUT
module accelerator_standard_fnn_sequencer
   import accelerator_standard_fnn_sequencer_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input logic                            CLK,
   input logic                            RST,
   accelerator_standard_fnn_sequencer_if.master bus
);
   state_t                  state, state_next;
   phase_t                  phase;
   phase_dims_t             cur_dims;
   logic [CONTROL_SIZE-1:0] size_x, size_w, size_l, size_r;
   logic [CONTROL_SIZE-1:0] eff_x, eff_w, eff_l, eff_r;
   logic [CONTROL_SIZE-1:0] size_outer, size_mid, size_inner;
   logic [NUM_PHASES-1:0]   phase_nonempty;
   logic                    in_load, xfer, zero_inner, zero_mid, last_elem;
   logic [DATA_SIZE-1:0]    data_q, dst_data;
   fnn_en_t                 en_q;
   logic [CONTROL_SIZE-1:0] h_count;
   logic                    ready_seen, dst_valid;

   function automatic logic [CONTROL_SIZE-1:0] pick(input dim_t d,
         input logic [CONTROL_SIZE-1:0] x, w, l, r);
      case (d)
         DIM_X:   return x;
         DIM_W:   return w;
         DIM_L:   return l;
         DIM_R:   return r;
         default: return CONTROL_SIZE'(1);
      endcase
   endfunction

   // Lowest non-empty phase at or after 'from'; RUN when nothing is left to load
   function automatic state_t first_load(input logic [NUM_PHASES-1:0] ne, input int from);
      state_t s;
      s = S_RUN;
      for (int i = NUM_PHASES - 1; i >= 0; i--)
         if (i >= from && ne[i]) s = state_t'(4'(i + 1));
      return s;
   endfunction

   assign in_load  = (state >= S_LOAD_W) && (state <= S_LOAD_H);
   assign phase    = phase_t'(3'(4'(state) - 4'(S_LOAD_W)));
   assign xfer     = bus.SRC_VALID && in_load;
   assign cur_dims = phase_dims(phase);

   // Sizes are only latched on the start edge, so IDLE plans the skip from the live inputs
   always_comb begin
      eff_x = size_x;
      eff_w = size_w;
      eff_l = size_l;
      eff_r = size_r;
      if (state == S_IDLE) begin
         eff_x = bus.SIZE_X_IN;
         eff_w = bus.SIZE_W_IN;
         eff_l = bus.SIZE_L_IN;
         eff_r = bus.SIZE_R_IN;
      end
      phase_nonempty = '0;
      for (int p = 0; p < NUM_PHASES; p++)
         phase_nonempty[p] =
            (pick(phase_dims(phase_t'(3'(p))).outer, eff_x, eff_w, eff_l, eff_r) != '0) &&
            (pick(phase_dims(phase_t'(3'(p))).mid,   eff_x, eff_w, eff_l, eff_r) != '0) &&
            (pick(phase_dims(phase_t'(3'(p))).inner, eff_x, eff_w, eff_l, eff_r) != '0);
   end

   assign size_outer = pick(cur_dims.outer, size_x, size_w, size_l, size_r);
   assign size_mid   = pick(cur_dims.mid,   size_x, size_w, size_l, size_r);
   assign size_inner = pick(cur_dims.inner, size_x, size_w, size_l, size_r);

   accelerator_standard_fnn_index_counter #(.WIDTH(CONTROL_SIZE)) u_index (
      .clk        (CLK),
      .rst_n      (RST),
      .clear      (state == S_IDLE),
      .inc        (xfer),
      .size_outer (size_outer),
      .size_mid   (size_mid),
      .size_inner (size_inner),
      .zero_inner (zero_inner),
      .zero_mid   (zero_mid),
      .last       (last_elem)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (bus.CTRL_START) state_next = first_load(phase_nonempty, 0);
         S_LOAD_W, S_LOAD_K, S_LOAD_U, S_LOAD_B, S_LOAD_X, S_LOAD_R, S_LOAD_H:
                    if (xfer && last_elem) state_next = first_load(phase_nonempty, int'(phase) + 1);
         S_RUN:     state_next = S_COLLECT;
         S_COLLECT: if (h_count == size_l && ready_seen) state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.CTRL_BUSY = (state != S_IDLE);
      bus.CTRL_DONE = (state == S_DONE);
      bus.SRC_READY = in_load;
      bus.FNN_START = (state == S_RUN);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         size_x <= '0;
         size_w <= '0;
         size_l <= '0;
         size_r <= '0;
      end else if (state == S_IDLE && bus.CTRL_START) begin
         size_x <= bus.SIZE_X_IN;
         size_w <= bus.SIZE_W_IN;
         size_l <= bus.SIZE_L_IN;
         size_r <= bus.SIZE_R_IN;
      end
   end

   // Outer enables flag the first element of each outer row, i.e. when all inner indices are zero
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q <= '0;
         en_q   <= '0;
      end else begin
         en_q <= '0;
         if (xfer) begin
            data_q <= bus.SRC_DATA;
            case (phase)
               PH_W: begin en_q.w_x <= 1'b1; en_q.w_l <= zero_inner; end
               PH_K: begin
                  en_q.k_k <= 1'b1;
                  en_q.k_l <= zero_inner;
                  en_q.k_i <= zero_inner && zero_mid;
               end
               PH_U: begin en_q.u_p <= 1'b1; en_q.u_l <= zero_inner; end
               PH_B: en_q.b <= 1'b1;
               PH_X: en_q.x <= 1'b1;
               PH_R: begin en_q.r_k <= 1'b1; en_q.r_i <= zero_inner; end
               default: en_q.h <= 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         h_count    <= '0;
         ready_seen <= 1'b0;
         dst_valid  <= 1'b0;
         dst_data   <= '0;
      end else begin
         dst_valid <= 1'b0;
         if (state == S_IDLE) begin
            h_count    <= '0;
            ready_seen <= 1'b0;
         end
         if (state == S_COLLECT) begin
            if (bus.FNN_READY) ready_seen <= 1'b1;
            if (bus.FNN_H_OUT_ENABLE && h_count != size_l) begin
               dst_data  <= bus.FNN_H_OUT;
               dst_valid <= 1'b1;
               h_count   <= h_count + CONTROL_SIZE'(1);
            end
         end
      end
   end

   assign bus.FNN_W_IN_L_ENABLE = en_q.w_l;
   assign bus.FNN_W_IN_X_ENABLE = en_q.w_x;
   assign bus.FNN_K_IN_I_ENABLE = en_q.k_i;
   assign bus.FNN_K_IN_L_ENABLE = en_q.k_l;
   assign bus.FNN_K_IN_K_ENABLE = en_q.k_k;
   assign bus.FNN_U_IN_L_ENABLE = en_q.u_l;
   assign bus.FNN_U_IN_P_ENABLE = en_q.u_p;
   assign bus.FNN_B_IN_ENABLE   = en_q.b;
   assign bus.FNN_X_IN_ENABLE   = en_q.x;
   assign bus.FNN_R_IN_I_ENABLE = en_q.r_i;
   assign bus.FNN_R_IN_K_ENABLE = en_q.r_k;
   assign bus.FNN_H_IN_ENABLE   = en_q.h;
   assign bus.FNN_W_IN = data_q;
   assign bus.FNN_K_IN = data_q;
   assign bus.FNN_U_IN = data_q;
   assign bus.FNN_B_IN = data_q;
   assign bus.FNN_X_IN = data_q;
   assign bus.FNN_R_IN = data_q;
   assign bus.FNN_H_IN = data_q;
   assign bus.DST_VALID = dst_valid;
   assign bus.DST_DATA  = dst_data;
endmodule

// File: tb/tb_accelerator_standard_fnn_sequencer.sv
// tb/tb_accelerator_standard_fnn_sequencer.sv - directed bench for the standard FNN sequencer
module tb_accelerator_standard_fnn_sequencer;
   localparam int DS = 64;
   localparam int CS = 64;

   // {W_L, W_X, K_I, K_L, K_K, U_L, U_P, B, X, R_I, R_K, H} for words 1..20 at X=2,W=2,L=2,R=1
   localparam logic [11:0] EXP_EN [20] = '{
      12'b1100_0000_0000, 12'b0100_0000_0000, 12'b1100_0000_0000, 12'b0100_0000_0000,
      12'b0011_1000_0000, 12'b0000_1000_0000, 12'b0001_1000_0000, 12'b0000_1000_0000,
      12'b0000_0110_0000, 12'b0000_0010_0000, 12'b0000_0110_0000, 12'b0000_0010_0000,
      12'b0000_0001_0000, 12'b0000_0001_0000, 12'b0000_0000_1000, 12'b0000_0000_1000,
      12'b0000_0000_0110, 12'b0000_0000_0010, 12'b0000_0000_0001, 12'b0000_0000_0001
   };
   localparam logic [11:0] KR_MASK = 12'b0011_1000_0110;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   accelerator_standard_fnn_sequencer_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

   accelerator_standard_fnn_sequencer #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int cyc    = 0;
   int start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0;
   logic [11:0] en_vec;
   logic        out_any;
   logic [63:0] log_data [$];
   logic [11:0] log_en [$];
   int          log_cyc [$];
   logic [63:0] dst_q [$];
   int          dst_cyc [$];

   assign en_vec = {bus.FNN_W_IN_L_ENABLE, bus.FNN_W_IN_X_ENABLE, bus.FNN_K_IN_I_ENABLE,
                    bus.FNN_K_IN_L_ENABLE, bus.FNN_K_IN_K_ENABLE, bus.FNN_U_IN_L_ENABLE,
                    bus.FNN_U_IN_P_ENABLE, bus.FNN_B_IN_ENABLE, bus.FNN_X_IN_ENABLE,
                    bus.FNN_R_IN_I_ENABLE, bus.FNN_R_IN_K_ENABLE, bus.FNN_H_IN_ENABLE};
   assign out_any = |{bus.CTRL_BUSY, bus.CTRL_DONE, bus.SRC_READY, bus.FNN_START, en_vec,
                      bus.DST_VALID, bus.DST_DATA, bus.FNN_W_IN, bus.FNN_K_IN, bus.FNN_U_IN,
                      bus.FNN_B_IN, bus.FNN_X_IN, bus.FNN_R_IN, bus.FNN_H_IN};

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (en_vec != '0) begin
         log_data.push_back(bus.FNN_W_IN);
         log_en.push_back(en_vec);
         log_cyc.push_back(cyc);
      end
      if (bus.DST_VALID) begin
         dst_q.push_back(bus.DST_DATA);
         dst_cyc.push_back(cyc);
      end
      if (bus.FNN_START) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
      if (bus.CTRL_DONE) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      log_data.delete();
      log_en.delete();
      log_cyc.delete();
      dst_q.delete();
      dst_cyc.delete();
      start_cnt = 0;
      done_cnt  = 0;
   endtask

   task automatic go(input int x, input int w, input int l, input int r);
      @(negedge CLK);
      bus.SIZE_X_IN = 64'(x);
      bus.SIZE_W_IN = 64'(w);
      bus.SIZE_L_IN = 64'(l);
      bus.SIZE_R_IN = 64'(r);
      bus.CTRL_START = 1'b1;
      @(negedge CLK);
      bus.CTRL_START = 1'b0;
   endtask

   task automatic send(input int first, input int last, input bit gaps);
      int  w = first;
      int  guard = 0;
      bit  hole = 1'b0;
      while (w <= last && guard < 200) begin
         @(negedge CLK);
         guard++;
         bus.SRC_VALID = !hole;
         bus.SRC_DATA  = 64'(w);
         if (!hole && bus.SRC_READY) w++;
         if (gaps) hole = !hole;
      end
      @(negedge CLK);
      bus.SRC_VALID = 1'b0;
      if (w <= last) chk("send_timeout", 64'(w), 64'(last + 1));
   endtask

   task automatic wait_start(input string tag);
      int k = 0;
      while (!bus.FNN_START && k < 40) begin
         @(negedge CLK);
         k++;
      end
      chk(tag, 64'(bus.FNN_START), 64'd1);
      #1;
   endtask

   task automatic verify_words(input string tag, input int n, input bit with_en);
      chk({tag, "_count"}, 64'(log_data.size()), 64'(n));
      if (log_data.size() == n)
         for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i + 1), log_data[i], 64'(i + 1));
            if (with_en)
               chk($sformatf("%s_en%0d", tag, i + 1), 64'(log_en[i]), 64'(EXP_EN[i]));
         end
   endtask

   task automatic collect2(input logic [63:0] a, input logic [63:0] b);
      @(negedge CLK);
      bus.FNN_H_OUT_ENABLE = 1'b1;
      bus.FNN_H_OUT = a;
      @(negedge CLK);
      bus.FNN_H_OUT = b;
      bus.FNN_READY = 1'b1;
      @(negedge CLK);
      bus.FNN_H_OUT_ENABLE = 1'b0;
      bus.FNN_READY = 1'b0;
      repeat (4) @(negedge CLK);
      #1;
   endtask

   task automatic check_dst(input string tag, input logic [63:0] a, input logic [63:0] b);
      chk({tag, "_dst_count"}, 64'(dst_q.size()), 64'd2);
      chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      if (dst_q.size() == 2) begin
         chk({tag, "_dst0"}, dst_q[0], a);
         chk({tag, "_dst1"}, dst_q[1], b);
         chk({tag, "_done_after_dst"}, 64'(done_cyc), 64'(dst_cyc[1] + 1));
      end
      chk({tag, "_busy_low"}, 64'(bus.CTRL_BUSY), 64'd0);
   endtask

   initial begin
      logic [11:0] kr;
      bus.CTRL_START = 1'b0;
      bus.SIZE_X_IN = '0;
      bus.SIZE_W_IN = '0;
      bus.SIZE_L_IN = '0;
      bus.SIZE_R_IN = '0;
      bus.SRC_VALID = 1'b0;
      bus.SRC_DATA = '0;
      bus.FNN_READY = 1'b0;
      bus.FNN_H_OUT_ENABLE = 1'b0;
      bus.FNN_H_OUT = '0;

      #2 RST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("reset_outputs", 64'(out_any), 64'd0);
      chk("reset_ready", 64'(bus.SRC_READY), 64'd0);
      RST = 1'b1;

      // back-to-back stream, H_OUT 0xA then 0xB with READY on 0xB
      clear_logs();
      go(2, 2, 2, 1);
      chk("t1_busy", 64'(bus.CTRL_BUSY), 64'd1);
      send(1, 20, 1'b0);
      wait_start("t1_start");
      verify_words("t1", 20, 1'b1);
      chk("t1_start_count", 64'(start_cnt), 64'd1);
      if (log_cyc.size() == 20)
         chk("t1_start_cycle", 64'(start_cyc), 64'(log_cyc[19]));
      chk("t1_ready_low", 64'(bus.SRC_READY), 64'd0);
      collect2(64'hA, 64'hB);
      check_dst("t1", 64'hA, 64'hB);

      // valid toggled 1/0; READY before any H_OUT, third H_OUT ignored
      clear_logs();
      go(2, 2, 2, 1);
      send(1, 20, 1'b1);
      wait_start("t2_start");
      verify_words("t2", 20, 1'b1);
      if (log_cyc.size() == 20)
         chk("t2_spacing", 64'(log_cyc[19] - log_cyc[0]), 64'd38);
      @(negedge CLK);
      bus.FNN_READY = 1'b1;
      @(negedge CLK);
      bus.FNN_READY = 1'b0;
      bus.FNN_H_OUT_ENABLE = 1'b1;
      bus.FNN_H_OUT = 64'h11;
      @(negedge CLK);
      bus.FNN_H_OUT = 64'h22;
      @(negedge CLK);
      bus.FNN_H_OUT = 64'h33;
      @(negedge CLK);
      bus.FNN_H_OUT_ENABLE = 1'b0;
      repeat (4) @(negedge CLK);
      #1;
      check_dst("t2", 64'h11, 64'h22);

      // R=0 skips K and R
      clear_logs();
      go(2, 2, 2, 0);
      send(1, 14, 1'b0);
      wait_start("t3_start");
      verify_words("t3", 14, 1'b0);
      kr = '0;
      for (int i = 0; i < log_en.size(); i++) kr = kr | (log_en[i] & KR_MASK);
      chk("t3_no_kr", 64'(kr), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;

      // reset during LOAD_K
      clear_logs();
      go(2, 2, 2, 1);
      send(1, 6, 1'b0);
      #2 RST = 1'b0;
      #1;
      chk("t4_abort_outputs", 64'(out_any), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      #1;
      chk("t4_no_done", 64'(done_cnt), 64'd0);
      chk("t4_idle_busy", 64'(bus.CTRL_BUSY), 64'd0);
      chk("t4_idle_ready", 64'(bus.SRC_READY), 64'd0);

      // CTRL_START with different sizes during LOAD_U is ignored
      clear_logs();
      go(2, 2, 2, 1);
      send(1, 10, 1'b0);
      @(negedge CLK);
      bus.SIZE_L_IN = 64'd3;
      bus.SIZE_X_IN = 64'd5;
      bus.CTRL_START = 1'b1;
      @(negedge CLK);
      bus.CTRL_START = 1'b0;
      send(11, 20, 1'b0);
      wait_start("t5_start");
      verify_words("t5", 20, 1'b1);
      collect2(64'hC, 64'hD);
      check_dst("t5", 64'hC, 64'hD);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
